// File: rtl/ppb_pkg.sv
// Shared state type, Fibonacci program image and PPB pin map for the program loader.
package ppb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PROG,
        WRITE,
        FIB,
        RELEASE
    } ppb_load_state_t;

    localparam int unsigned FIB_LEN = 16;

    // Built-in Fibonacci program, written to addresses 0..FIB_LEN-1 on a preload request.
    localparam logic [7:0] FIB_PROG [FIB_LEN] = '{
        8'h10, 8'h00, 8'h11, 8'h01,
        8'h22, 8'h01, 8'h30, 8'hF0,
        8'h41, 8'h50, 8'h12, 8'h60,
        8'h04, 8'h00, 8'hFF, 8'h00
    };

    localparam int unsigned PPB_BIT_ADDR_LO = 3;
    localparam int unsigned PPB_BIT_DATA_LO = 11;
    localparam int unsigned PPB_BIT_PROG_EN = 19;
    localparam int unsigned PPB_BIT_FIB     = 20;
    localparam int unsigned PPB_BIT_WRITE   = 21;

endpackage

// File: rtl/ppb_input_conditioner.sv
// Synchronizer, debouncer and rising-edge request generator for one PPB strobe input.
module ppb_input_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_req
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_stable;
    logic                   r_req;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign o_req    = r_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_req    <= 1'b0;
        end else begin
            r_sync <= (r_sync << 1) | SYNC_STAGES'(i_async);
            r_req  <= 1'b0;
            if (w_synced == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                // Request fires together with the stable update, on 0->1 only.
                r_cnt    <= '0;
                r_stable <= w_synced;
                r_req    <= w_synced;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ppb_program_loader.sv
// Turns PPB programming inputs into single-cycle program-memory writes and holds the CPU in reset meanwhile.
module ppb_program_loader
    import ppb_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        prog_en_in,
    input  logic [7:0]  prog_addr_in,
    input  logic [7:0]  prog_data_in,
    input  logic        prog_write_in,
    input  logic        fib_prog_in,
    output logic        cpu_hold,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        busy,
    output logic [7:0]  write_count
);

    localparam int unsigned IDX_W = $clog2(FIB_LEN);

    logic [16:0]      r_bus_sync [SYNC_STAGES];
    ppb_load_state_t  r_state;
    logic [IDX_W-1:0] r_idx;

    logic             w_prog_en;
    logic [7:0]       w_addr;
    logic [7:0]       w_data;
    logic             w_wr_req;
    logic             w_fib_req;
    logic [IDX_W-1:0] w_idx_next;

    assign {w_prog_en, w_addr, w_data} = r_bus_sync[SYNC_STAGES-1];
    assign w_idx_next = r_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) r_bus_sync[s] <= '0;
        end else begin
            r_bus_sync[0] <= {prog_en_in, prog_addr_in, prog_data_in};
            for (int unsigned s = 1; s < SYNC_STAGES; s++) r_bus_sync[s] <= r_bus_sync[s-1];
        end
    end

    ppb_input_conditioner #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_wr_cond (
        .clk    (clk),
        .reset  (reset),
        .i_async(prog_write_in),
        .o_req  (w_wr_req)
    );

    ppb_input_conditioner #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_fib_cond (
        .clk    (clk),
        .reset  (reset),
        .i_async(fib_prog_in),
        .o_req  (w_fib_req)
    );

    // Outputs are registered on state entry so a write is visible in the same cycle as WRITE/FIB.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            cpu_hold    <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            busy        <= 1'b0;
            write_count <= '0;
        end else begin
            mem_we <= 1'b0;
            busy   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fib_req) begin
                        r_state     <= FIB;
                        r_idx       <= '0;
                        cpu_hold    <= 1'b1;
                        mem_we      <= 1'b1;
                        busy        <= 1'b1;
                        mem_addr    <= '0;
                        mem_wdata   <= FIB_PROG[0];
                        write_count <= write_count + 8'd1;
                    end else if (w_prog_en) begin
                        r_state  <= PROG;
                        cpu_hold <= 1'b1;
                    end
                end
                PROG: begin
                    if (w_fib_req) begin
                        r_state     <= FIB;
                        r_idx       <= '0;
                        mem_we      <= 1'b1;
                        busy        <= 1'b1;
                        mem_addr    <= '0;
                        mem_wdata   <= FIB_PROG[0];
                        write_count <= write_count + 8'd1;
                    end else if (w_wr_req) begin
                        r_state     <= WRITE;
                        mem_we      <= 1'b1;
                        busy        <= 1'b1;
                        mem_addr    <= {8'h00, w_addr};
                        mem_wdata   <= w_data;
                        write_count <= write_count + 8'd1;
                    end else if (!w_prog_en) begin
                        r_state <= RELEASE;
                    end
                end
                WRITE: begin
                    r_state <= PROG;
                end
                FIB: begin
                    if (r_idx == IDX_W'(FIB_LEN - 1)) begin
                        r_idx   <= '0;
                        r_state <= w_prog_en ? PROG : RELEASE;
                    end else begin
                        r_idx       <= w_idx_next;
                        mem_we      <= 1'b1;
                        busy        <= 1'b1;
                        mem_addr    <= {8'h00, 8'(w_idx_next)};
                        mem_wdata   <= FIB_PROG[w_idx_next];
                        write_count <= write_count + 8'd1;
                    end
                end
                RELEASE: begin
                    r_state  <= IDLE;
                    cpu_hold <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    cpu_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ppb_program_loader.md
Name: ppb_program_loader

Overview:
Consumes the programming-side PPB device inputs (enable, address, data, write strobe, Fibonacci preload request) and turns them into clean single-cycle writes into CPU program memory. Holds the CPU in reset while programming is active. Sits between the PPB input mapping and the memory write port, in parallel with the CPU's own memory path, which is muxed off while `cpu_hold` is high.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on every asynchronous PPB input.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before `prog_write_in` or `fib_prog_in` is accepted.
- FIB_LEN, 16: number of bytes in the built-in Fibonacci program image.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- prog_en_in  in  1  PPB programming enable (device input 19).
- prog_addr_in  in  8  PPB programming address (device inputs 3..10).
- prog_data_in  in  8  PPB programming data (device inputs 11..18).
- prog_write_in  in  1  PPB write strobe, level; a write is requested on its rising edge (device input 21).
- fib_prog_in  in  1  PPB Fibonacci preload request; a preload is requested on its rising edge (device input 20).
- cpu_hold  out  1  high while loading; the CPU is held in reset and the memory mux selects the loader.
- mem_addr  out  16  write address, equal to {8'h00, byte address}.
- mem_wdata  out  8  write data.
- mem_we  out  1  memory write enable, one cycle per byte.
- busy  out  1  high in WRITE or FIB.
- write_count  out  8  bytes written since reset; wraps 255 -> 0.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; synchronizers, debounce counters and ROM index cleared.
- Input conditioning:
  - Every input passes through a SYNC_STAGES flop chain.
  - `prog_write_in` and `fib_prog_in` each have a debounce counter. The counter counts consecutive cycles in which the synced value differs from the stable value. When it reaches DEBOUNCE_CYCLES-1, the stable value updates; any match resets the counter.
  - A 0->1 transition of a stable value produces a one-cycle request (`wr_req` or `fib_req`).
- `wr_req` latches the synced address and data in the same cycle.
- Latency: from a `prog_write_in` rising edge, with address and data held steady, to `mem_we` high is SYNC_STAGES+DEBOUNCE_CYCLES+1 clocks (19 with defaults).
- FSM states: IDLE, PROG, WRITE, FIB, RELEASE.
  - IDLE: `cpu_hold`=0.
    - `fib_req` -> FIB.
    - else synced `prog_en`=1 -> PROG.
    - `wr_req` in IDLE is discarded.
  - PROG: `cpu_hold`=1.
    - `fib_req` -> FIB; this takes priority over a simultaneous `wr_req`, which is dropped.
    - else `wr_req` -> WRITE.
    - else `prog_en`=0 -> RELEASE.
  - WRITE: one cycle; `mem_we`=1, `mem_addr`/`mem_wdata` = latched values, `write_count`+1. Next state is always PROG.
  - FIB: `mem_we`=1 for FIB_LEN consecutive cycles.
    - Index i runs 0..FIB_LEN-1; `mem_addr`={8'h00,i}, `mem_wdata`=FIB_PROG[i]; `write_count`+1 per cycle.
    - After i=FIB_LEN-1: `prog_en`=1 -> PROG, else -> RELEASE.
    - `wr_req` and `fib_req` arriving during FIB are dropped.
    - `prog_en` falling during FIB does not abort the stream.
  - RELEASE: `cpu_hold` stays 1 for exactly this one cycle, then IDLE. This guarantees the CPU leaves reset with memory quiescent.
- Output behaviour outside writes:
  - `mem_we` is 0 in every state other than WRITE and FIB.
  - `mem_addr` and `mem_wdata` hold their last driven value when `mem_we`=0.
- `busy` = (state==WRITE || state==FIB).
- Reset asserted mid-WRITE or mid-FIB: the next cycle is IDLE with all outputs 0. The partial image stays in memory; there is no rollback.
- Glitches shorter than DEBOUNCE_CYCLES on the strobes never generate a request.

Decomposition:
- Package `ppb_pkg`:
  - state enum `ppb_load_state_t` {IDLE, PROG, WRITE, FIB, RELEASE};
  - constant FIB_LEN;
  - constant array FIB_PROG[FIB_LEN] of 8-bit opcodes/operands (the Fibonacci program image);
  - PPB input bit index constants (19, 20, 21, 3, 11).
- Sub-module `ppb_input_conditioner` (sync + debounce + rising-edge request, parameterised by SYNC_STAGES and DEBOUNCE_CYCLES), instantiated twice. Address and data use the plain synchronizer path only.

Test Plan:
- Reset check: assert reset 3 cycles -> `cpu_hold`=0, `mem_we`=0, `write_count`=0, `busy`=0.
- Single write: `prog_en`=1, then addr=8'h05, data=8'hA7, then raise `prog_write_in` -> `cpu_hold`=1; `mem_we` high for exactly 1 cycle, 19 clocks after the edge, with `mem_addr`=16'h0005, `mem_wdata`=8'hA7; `write_count`=1.
- Glitch rejection: pulse `prog_write_in` high for 10 cycles while in PROG -> no `mem_we`, `write_count` unchanged.
- Fibonacci preload: raise `fib_prog_in` from IDLE with `prog_en`=0 -> 16 consecutive `mem_we` cycles, addresses 0..15, data = FIB_PROG[i], `write_count`=16; then RELEASE for 1 cycle, then `cpu_hold`=0.
- Release timing: in PROG, drop `prog_en` -> `cpu_hold` falls exactly SYNC_STAGES+2 clocks later; no `mem_we` in that window.
- Reset mid-FIB: assert reset at i=7 -> `mem_we`=0 the next cycle, state IDLE, `write_count`=0; a following `fib_req` restarts at address 0.
